// File: rtl/npc_if.sv
// npc_if: groups the next-PC unit's pipeline-facing signals.
//   master modport : pipeline side; drives pc, stall, redirect requests;
//                    receives npc, epc, flush, pending.
//   slave modport  : npc_unit side; the opposite directions.
interface npc_if;
  logic [29:0] pc;
  logic        stall;
  logic        br_taken;
  logic [29:0] br_target;
  logic        jmp;
  logic [29:0] jmp_target;
  logic        exc;
  logic        eret;
  logic [29:0] npc;
  logic [29:0] epc;
  logic        flush;
  logic        pending;

  modport master (
    output pc, stall, br_taken, br_target, jmp, jmp_target, exc, eret,
    input  npc, epc, flush, pending
  );

  modport slave (
    input  pc, stall, br_taken, br_target, jmp, jmp_target, exc, eret,
    output npc, epc, flush, pending
  );
endinterface

// File: rtl/npc_unit.sv
// npc_unit: next-PC generator.
//   Produces the next fetch address npc[31:2] from the current pc.
//   Source priority is exception vector, eret, jump, branch, then sequential.
//   A redirect that arrives while stalled is parked in pend_addr (state HOLD)
//   and applied when the stall drops. An exception is never stalled.
//   The unit also owns the EPC register and raises a one-cycle flush after
//   every redirect that actually reaches npc.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active high (also forces npc to RESET_ADDR)
//   bus  - npc_if.slave: pc, stall, br_taken/br_target, jmp/jmp_target,
//          exc, eret in; npc (combinational), epc, flush, pending out
module npc_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input logic   clk,
  input logic   rst,
  npc_if.slave  bus
);

  localparam logic [29:0] RESET_W = RESET_ADDR[31:2];
  localparam logic [29:0] EXC_W   = EXC_VECTOR[31:2];

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [29:0] pend_addr_r, pend_addr_s;
  logic [29:0] epc_r, epc_s;
  logic        flush_r, flush_s;
  logic        redir_s;
  logic [29:0] redir_tgt_s;
  logic [29:0] npc_s;

  // Redirect detection and priority-ordered target selection.
  always_comb begin
    redir_s     = bus.exc | bus.eret | bus.jmp | bus.br_taken;
    redir_tgt_s = bus.pc;
    if (bus.exc) begin
      redir_tgt_s = EXC_W;
    end else if (bus.eret) begin
      redir_tgt_s = epc_r;   // old epc, never the value being written now
    end else if (bus.jmp) begin
      redir_tgt_s = bus.jmp_target;
    end else if (bus.br_taken) begin
      redir_tgt_s = bus.br_target;
    end else begin
      redir_tgt_s = bus.pc;
    end
  end

  // Next-state, next-PC, EPC capture and flush request.
  always_comb begin
    state_s     = state_r;
    pend_addr_s = pend_addr_r;
    epc_s       = epc_r;
    flush_s     = 1'b0;
    npc_s       = bus.pc;
    if (bus.exc) begin
      // Exceptions bypass the stall and discard any parked redirect.
      npc_s   = EXC_W;
      epc_s   = bus.pc;
      flush_s = 1'b1;
      state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (!bus.stall) begin
            if (redir_s) begin
              npc_s   = redir_tgt_s;
              flush_s = 1'b1;
            end else begin
              npc_s = bus.pc + 30'd1;   // 30-bit wrap is intended
            end
          end else begin
            npc_s = bus.pc;
            if (redir_s) begin
              pend_addr_s = redir_tgt_s;
              state_s     = HOLD;
            end else begin
              pend_addr_s = pend_addr_r;
            end
          end
        end
        HOLD: begin
          if (bus.stall) begin
            npc_s = bus.pc;
            // Newest redirect wins while still stalled.
            if (redir_s) begin
              pend_addr_s = redir_tgt_s;
            end else begin
              pend_addr_s = pend_addr_r;
            end
          end else begin
            // Release: parked target only; same-cycle redirects are ignored.
            npc_s   = pend_addr_r;
            flush_s = 1'b1;
            state_s = RUN;
          end
        end
        default: begin
          npc_s   = bus.pc;
          state_s = RUN;
        end
      endcase
    end
  end

  // Reset forces the fetch address regardless of the selected source.
  always_comb begin
    if (rst) begin
      bus.npc = RESET_W;
    end else begin
      bus.npc = npc_s;
    end
  end

  // State, parked target, EPC and flush registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      pend_addr_r <= 30'd0;
      epc_r       <= RESET_W;
      flush_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_addr_r <= pend_addr_s;
      epc_r       <= epc_s;
      flush_r     <= flush_s;
    end
  end

  assign bus.epc     = epc_r;
  assign bus.flush   = flush_r;
  assign bus.pending = (state_r == HOLD);

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed vectors for npc_unit with a queue-based scoreboard.
// Each vector drives inputs just after a falling edge and pushes the values
// expected before the next rising edge; a separate monitor pops and compares.
module tb_npc_unit;

  logic clk;
  logic rst;
  npc_if bif ();

  npc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  mask;      // {npc, epc, flush, pending}
    logic [29:0] npc;
    logic [29:0] epc;
    logic        flush;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];
  int checks;
  int errors;
  bit stim_done;

  task automatic drive(input logic r, input logic [29:0] p, input logic st,
                       input logic b, input logic [29:0] bt,
                       input logic j, input logic [29:0] jt,
                       input logic e, input logic er);
    @(negedge clk);
    rst            = r;
    bif.pc         = p;
    bif.stall      = st;
    bif.br_taken   = b;
    bif.br_target  = bt;
    bif.jmp        = j;
    bif.jmp_target = jt;
    bif.exc        = e;
    bif.eret       = er;
  endtask

  task automatic expect_o(input string n, input logic [3:0] m,
                          input logic [29:0] np, input logic [29:0] ep,
                          input logic fl, input logic pd);
    exp_t x;
    x.name = n; x.mask = m; x.npc = np; x.epc = ep; x.flush = fl; x.pend = pd;
    exp_q.push_back(x);
  endtask

  // Monitor: samples 2 time units after each falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.mask[3]) begin
          checks++;
          if (bif.npc !== x.npc) begin
            errors++;
            $display("FAIL %s npc got %h want %h", x.name, bif.npc, x.npc);
          end
        end
        if (x.mask[2]) begin
          checks++;
          if (bif.epc !== x.epc) begin
            errors++;
            $display("FAIL %s epc got %h want %h", x.name, bif.epc, x.epc);
          end
        end
        if (x.mask[1]) begin
          checks++;
          if (bif.flush !== x.flush) begin
            errors++;
            $display("FAIL %s flush got %b want %b", x.name, bif.flush, x.flush);
          end
        end
        if (x.mask[0]) begin
          checks++;
          if (bif.pending !== x.pend) begin
            errors++;
            $display("FAIL %s pending got %b want %b", x.name, bif.pending, x.pend);
          end
        end
      end
    end
  end

  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] NFP = 4'b1011;
  localparam logic [3:0] NF  = 4'b1010;
  localparam logic [3:0] NP  = 4'b1001;
  localparam logic [3:0] N   = 4'b1000;

  initial begin
    checks = 0; errors = 0; stim_done = 1'b0;
    rst = 1'b1;
    bif.pc = 30'd0; bif.stall = 1'b0; bif.br_taken = 1'b0; bif.br_target = 30'd0;
    bif.jmp = 1'b0; bif.jmp_target = 30'd0; bif.exc = 1'b0; bif.eret = 1'b0;

    // 1. Reset for two clocks, then sequential from RESET_ADDR.
    drive(1, 30'h0, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("rst1", ALL, 30'hC00, 30'hC00, 0, 0);
    drive(1, 30'h0, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("rst2", ALL, 30'hC00, 30'hC00, 0, 0);
    drive(0, 30'hC00, 0, 0, 30'h0, 0, 30'h0, 0, 0); expect_o("seq_after_rst", NFP, 30'hC01, 0, 0, 0);
    // 2. Taken branch then flush pulse.
    drive(0, 30'hC04, 0, 1, 30'hC10, 0, 30'h0, 0, 0); expect_o("branch", NF, 30'hC10, 0, 0, 0);
    drive(0, 30'hC10, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("br_flush", NF, 30'hC11, 0, 1, 0);
    drive(0, 30'hC11, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("br_flush_off", NF, 30'hC12, 0, 0, 0);
    // 3. Jump during stall is parked and released.
    drive(0, 30'hC08, 1, 0, 30'h0, 1, 30'hD00, 0, 0); expect_o("hold_cap", NFP, 30'hC08, 0, 0, 0);
    drive(0, 30'hC08, 1, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("hold1", NFP, 30'hC08, 0, 0, 1);
    drive(0, 30'hC08, 1, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("hold2", NP, 30'hC08, 0, 0, 1);
    drive(0, 30'hC08, 1, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("hold3", NP, 30'hC08, 0, 0, 1);
    drive(0, 30'hC08, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("release", NFP, 30'hD00, 0, 0, 1);
    drive(0, 30'hD00, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("release_flush", NFP, 30'hD01, 0, 1, 0);
    // 4. Exception over a held redirect, then eret.
    drive(0, 30'hC08, 1, 0, 30'h0, 1, 30'hD00, 0, 0); expect_o("hold_cap2", N, 30'hC08, 0, 0, 0);
    drive(0, 30'hC08, 1, 0, 30'h0, 0, 30'h0, 1, 0);   expect_o("exc_in_hold", ALL, 30'h1060, 30'hC00, 0, 1);
    drive(0, 30'h1060, 0, 0, 30'h0, 0, 30'h0, 0, 0);  expect_o("exc_after", ALL, 30'h1061, 30'hC08, 1, 0);
    drive(0, 30'h1061, 0, 0, 30'h0, 0, 30'h0, 0, 1);  expect_o("eret", NF, 30'hC08, 0, 0, 0);
    drive(0, 30'hC08, 0, 0, 30'h0, 0, 30'h0, 0, 0);   expect_o("eret_flush", NF, 30'hC09, 0, 1, 0);
    // 5. Priority (everything at once) and 30-bit wrap.
    drive(0, 30'hC09, 0, 1, 30'hC10, 1, 30'hD00, 1, 1); expect_o("prio_all", N, 30'h1060, 0, 0, 0);
    drive(0, 30'h1060, 0, 0, 30'h0, 0, 30'h0, 0, 0);    expect_o("prio_epc", 4'b1110, 30'h1061, 30'hC09, 1, 0);
    drive(0, 30'h3FFF_FFFF, 0, 0, 30'h0, 0, 30'h0, 0, 0); expect_o("wrap", NF, 30'h0, 0, 0, 0);
    // Newest redirect wins during HOLD; same-cycle jump at release ignored.
    drive(0, 30'h100, 1, 0, 30'h0, 1, 30'h200, 0, 0);   expect_o("hold_j", N, 30'h100, 0, 0, 0);
    drive(0, 30'h100, 1, 1, 30'h300, 0, 30'h0, 0, 0);   expect_o("hold_b", NP, 30'h100, 0, 0, 1);
    drive(0, 30'h100, 0, 0, 30'h0, 1, 30'h400, 0, 0);   expect_o("newest", N, 30'h300, 0, 0, 0);
    drive(0, 30'h300, 0, 0, 30'h0, 0, 30'h0, 0, 0);     expect_o("newest_after", NFP, 30'h301, 0, 1, 0);
    // Exception in RUN while stalled is not held.
    drive(0, 30'h500, 1, 0, 30'h0, 0, 30'h0, 1, 0);     expect_o("exc_stall", N, 30'h1060, 0, 0, 0);
    drive(0, 30'h1060, 0, 0, 30'h0, 0, 30'h0, 0, 0);    expect_o("exc_stall_after", ALL, 30'h1061, 30'h500, 1, 0);
    // 6. Reset while a redirect is parked.
    drive(0, 30'h600, 1, 0, 30'h0, 1, 30'h700, 0, 0);   expect_o("hold_cap3", N, 30'h600, 0, 0, 0);
    drive(0, 30'h600, 1, 0, 30'h0, 0, 30'h0, 0, 0);     expect_o("hold_pre_rst", NP, 30'h600, 0, 0, 1);
    drive(1, 30'h600, 1, 0, 30'h0, 0, 30'h0, 0, 0);     expect_o("rst_in_hold", N, 30'hC00, 0, 0, 0);
    drive(0, 30'hC00, 0, 0, 30'h0, 0, 30'h0, 0, 0);     expect_o("post_rst", ALL, 30'hC01, 30'hC00, 0, 0);

    drive(0, 30'hC01, 0, 0, 30'h0, 0, 30'h0, 0, 0);
    repeat (3) @(negedge clk);
    stim_done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #20000;
    if (!stim_done) begin
      $display("FAIL timeout stim_done %b want 1", stim_done);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
    end
  end

endmodule
